// File: rtl/fpu_sched.sv
// fpu_sched: issue/completion scheduler for the FPU unit array.
// Gates issue on per-unit busy state plus a per-FPR pending scoreboard,
// drives the one-hot unit select, captures unit results and serialises
// them onto one FPR writeback port with round-robin arbitration.
// Optional build macro FPU_SCHED_PERF_EN enables the perf_issue,
// perf_stall and perf_raw saturating counters; without it those
// outputs are tied to zero.
module fpu_sched #(
  parameter int NUNIT   = 9,
  parameter int NREG    = 32,
  parameter int RR_INIT = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    iss_valid,
  output logic                    iss_ready,
  input  logic [3:0]              iss_op,
  input  logic [$clog2(NREG)-1:0] iss_rd,
  input  logic [$clog2(NREG)-1:0] iss_rs1,
  input  logic [$clog2(NREG)-1:0] iss_rs2,
  input  logic                    iss_use_rs2,
  output logic [NUNIT:0]          fpu_in_valid,
  input  logic [NUNIT:0]          unit_ready,
  input  logic [NUNIT:0]          unit_out_valid,
  input  logic [NUNIT:0][31:0]    unit_out,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [$clog2(NREG)-1:0] wb_rd,
  output logic [31:0]             wb_data,
  output logic [NUNIT:0]          busy,
  output logic                    err_illegal,
  output logic                    err_spurious,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_stall,
  output logic [31:0]             perf_raw
);

  localparam int RW = $clog2(NREG);
  localparam int UW = $clog2(NUNIT + 1);
  // fcmp only produces a result in the low byte; the rest is cleared
  localparam int FCMP_UNIT = 7;
  // index 0 means "no unit" and never takes part in any decision
  localparam logic [NUNIT:0] UNIT_MASK = {{NUNIT{1'b1}}, 1'b0};

  // registered state
  logic [NUNIT:0]   busy_reg, busy_next;
  logic [NUNIT:0]   cap_v_reg, cap_v_next;
  logic [NREG-1:0]  pend_reg, pend_next;
  logic [UW-1:0]    rr_reg, rr_next;
  logic             lock_v_reg, lock_v_next;
  logic [UW-1:0]    lock_g_reg, lock_g_next;
  logic             err_ill_reg, err_ill_next;
  logic             err_spur_reg, err_spur_next;
  logic [RW-1:0]    tag_reg   [0:NUNIT];
  logic [31:0]      cap_d_reg [0:NUNIT];

  // issue-side combinational terms
  logic             op_legal;
  logic [UW-1:0]    op_idx;
  logic             sb_hit;
  logic             unit_free;
  logic             accept;
  logic             dispatch;
  logic [NUNIT:0]   ready_masked;

  // completion-side combinational terms
  logic [NUNIT:0]       cap_en;
  logic [NUNIT:0]       spur_hit;
  logic [NUNIT:0][31:0] cap_val;
  logic [UW-1:0]        grant_calc;
  logic [UW-1:0]        grant;
  logic                 found;
  int                   cand;
  logic                 wb_fire;

  assign op_legal     = (iss_op != 4'd0) && (32'(iss_op) <= 32'(NUNIT));
  assign op_idx       = op_legal ? UW'(iss_op) : '0;
  assign ready_masked = unit_ready & UNIT_MASK;
  assign sb_hit       = pend_reg[iss_rs1] | (iss_use_rs2 & pend_reg[iss_rs2]) | pend_reg[iss_rd];
  assign unit_free    = op_legal && !busy_reg[op_idx] && ready_masked[op_idx];
  // illegal ops are always swallowed so they cannot wedge the issue stage
  assign iss_ready    = op_legal ? (unit_free && !sb_hit) : 1'b1;
  assign accept       = iss_valid && iss_ready;
  assign dispatch     = accept && op_legal;

  assign cap_en   = unit_out_valid & UNIT_MASK & busy_reg & ~cap_v_reg;
  assign spur_hit = unit_out_valid & UNIT_MASK & ~busy_reg;

  // per-unit select decode and result shaping
  generate
    for (genvar gi = 0; gi <= NUNIT; gi++) begin : g_unit
      assign fpu_in_valid[gi] = dispatch && UNIT_MASK[gi] && (op_idx == UW'(gi));
      if (gi == FCMP_UNIT) begin : g_fcmp
        assign cap_val[gi] = {24'd0, unit_out[gi][7:0]};
      end else begin : g_plain
        assign cap_val[gi] = unit_out[gi];
      end
    end
  endgenerate

  // round-robin search: first captured unit at or after rr, wrapping NUNIT -> 1
  always_comb begin
    grant_calc = '0;
    found      = 1'b0;
    cand       = 0;
    for (int off = 0; off < NUNIT; off++) begin
      cand = 32'(rr_reg) + off;
      if (cand > NUNIT) cand = cand - NUNIT;
      if (!found && cap_v_reg[UW'(cand)]) begin
        grant_calc = UW'(cand);
        found      = 1'b1;
      end
    end
  end

  // a stalled writeback keeps its grant even if a new capture would win the search
  assign grant    = lock_v_reg ? lock_g_reg : grant_calc;
  assign wb_valid = |cap_v_reg;
  assign wb_rd    = tag_reg[grant];
  assign wb_data  = cap_d_reg[grant];
  assign wb_fire  = wb_valid && wb_ready;
  assign busy     = busy_reg;
  assign err_illegal  = err_ill_reg;
  assign err_spurious = err_spur_reg;

  // next-state for busy, capture valids, scoreboard, pointer and flags
  always_comb begin
    busy_next     = busy_reg;
    cap_v_next    = cap_v_reg;
    pend_next     = pend_reg;
    rr_next       = rr_reg;
    lock_v_next   = wb_valid && !wb_ready;
    lock_g_next   = grant;
    err_ill_next  = err_ill_reg | (accept && !op_legal);
    err_spur_next = err_spur_reg | (|spur_hit);
    if (wb_fire) begin
      busy_next[grant]          = 1'b0;
      cap_v_next[grant]         = 1'b0;
      pend_next[tag_reg[grant]] = 1'b0;
      rr_next = (grant == UW'(NUNIT)) ? UW'(1) : grant + UW'(1);
    end
    // a dispatch never targets a retiring unit or register: both are still
    // marked in registered state, so the issue would have been stalled
    if (dispatch) begin
      busy_next[op_idx] = 1'b1;
      pend_next[iss_rd] = 1'b1;
    end
    cap_v_next = cap_v_next | cap_en;
  end

  // control state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_reg     <= '0;
      cap_v_reg    <= '0;
      pend_reg     <= '0;
      rr_reg       <= UW'(RR_INIT);
      lock_v_reg   <= 1'b0;
      lock_g_reg   <= '0;
      err_ill_reg  <= 1'b0;
      err_spur_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      cap_v_reg    <= cap_v_next;
      pend_reg     <= pend_next;
      rr_reg       <= rr_next;
      lock_v_reg   <= lock_v_next;
      lock_g_reg   <= lock_g_next;
      err_ill_reg  <= err_ill_next;
      err_spur_reg <= err_spur_next;
    end
  end

  // per-unit destination tags and captured results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k <= NUNIT; k++) begin
        tag_reg[k]   <= '0;
        cap_d_reg[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= NUNIT; k++) begin
        if (dispatch && (op_idx == UW'(k))) tag_reg[k] <= iss_rd;
        if (cap_en[k]) cap_d_reg[k] <= cap_val[k];
      end
    end
  end

`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_issue_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_raw_reg;
  logic        stall_cyc;
  logic        raw_cyc;

  // a stall always means a legal op, since illegal ops are always accepted
  assign stall_cyc = iss_valid && !iss_ready;
  assign raw_cyc   = stall_cyc && sb_hit;

  // saturating event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
      perf_raw_reg   <= '0;
    end else begin
      if (dispatch && (perf_issue_reg != '1)) perf_issue_reg <= perf_issue_reg + 32'd1;
      if (stall_cyc && (perf_stall_reg != '1)) perf_stall_reg <= perf_stall_reg + 32'd1;
      if (raw_cyc && (perf_raw_reg != '1)) perf_raw_reg <= perf_raw_reg + 32'd1;
    end
  end

  assign perf_issue = perf_issue_reg;
  assign perf_stall = perf_stall_reg;
  assign perf_raw   = perf_raw_reg;
`else
  assign perf_issue = 32'd0;
  assign perf_stall = 32'd0;
  assign perf_raw   = 32'd0;
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: table-driven issue checks plus hand-written sequences for
// hazards, arbitration, fcmp masking, error flags and async reset; all
// writebacks are checked against a scoreboard queue.
module tb_fpu_sched;

  logic             clk = 1'b0;
  logic             rstn;
  logic             iss_valid;
  logic             iss_ready;
  logic [3:0]       iss_op;
  logic [4:0]       iss_rd, iss_rs1, iss_rs2;
  logic             iss_use_rs2;
  logic [9:0]       fpu_in_valid;
  logic [9:0]       unit_ready;
  logic [9:0]       unit_out_valid;
  logic [9:0][31:0] unit_out;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_data;
  logic [9:0]       busy;
  logic             err_illegal, err_spurious;
  logic [31:0]      perf_issue, perf_stall, perf_raw;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;
  wb_t sb_q[$];
  wb_t mon_exp;

  typedef struct {
    logic [3:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       use2;
    logic [9:0] ur;
    logic       exp_ready;
    logic [9:0] exp_fiv;
  } vec_t;
  vec_t tbl[12];

  fpu_sched dut (
    .clk(clk), .rstn(rstn),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_rd(iss_rd), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_use_rs2(iss_use_rs2),
    .fpu_in_valid(fpu_in_valid), .unit_ready(unit_ready),
    .unit_out_valid(unit_out_valid), .unit_out(unit_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .busy(busy), .err_illegal(err_illegal), .err_spurious(err_spurious),
    .perf_issue(perf_issue), .perf_stall(perf_stall), .perf_raw(perf_raw)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic use2, input logic [9:0] exp_fiv);
    iss_op = op; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2; iss_use_rs2 = use2;
    iss_valid = 1'b1;
    #1;
    chk("issue_ready", {31'd0, iss_ready}, 32'd1);
    chk("issue_sel", {22'd0, fpu_in_valid}, {22'd0, exp_fiv});
    $display("issue op=%0d rd=%0d rs1=%0d rs2=%0d sel=%h", op, rd, rs1, rs2, fpu_in_valid);
    step();
    iss_valid = 1'b0;
  endtask

  task automatic pulse(input int k, input logic [31:0] d, input logic [4:0] exp_rd,
                       input logic [31:0] exp_d, input bit push);
    unit_out[k] = d;
    unit_out_valid = '0;
    unit_out_valid[k] = 1'b1;
    if (push) sb_q.push_back('{exp_rd, exp_d});
    step();
    unit_out_valid = '0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && (sb_q.size() != 0 || wb_valid); i++) step();
    chk("drain", {31'd0, (sb_q.size() == 0) && !wb_valid}, 32'd1);
  endtask

  // scoreboard: every accepted writeback must match the oldest expectation
  always @(negedge clk) begin
    if (rstn && wb_valid && wb_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
      end else begin
        mon_exp = sb_q.pop_front();
        if (wb_rd !== mon_exp.rd || wb_data !== mon_exp.data) begin
          failures++;
          $display("FAIL wb_match: got rd=%0d data=%h expected rd=%0d data=%h",
                   wb_rd, wb_data, mon_exp.rd, mon_exp.data);
        end else begin
          $display("wb rd=%0d data=%h", wb_rd, wb_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    iss_valid = 1'b0; iss_op = '0; iss_rd = '0; iss_rs1 = '0; iss_rs2 = '0; iss_use_rs2 = 1'b0;
    unit_ready = '1; unit_out_valid = '0; unit_out = '0; wb_ready = 1'b1;

    // table: op rd rs1 rs2 use2 unit_ready exp_ready exp_sel (fmul rd=5 in flight)
    tbl[0]  = '{4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 10'h3FF, 1'b1, 10'h002};
    tbl[1]  = '{4'd1, 5'd3, 5'd5, 5'd2, 1'b1, 10'h3FF, 1'b0, 10'h000};
    tbl[2]  = '{4'd1, 5'd3, 5'd1, 5'd5, 1'b1, 10'h3FF, 1'b0, 10'h000};
    tbl[3]  = '{4'd1, 5'd3, 5'd1, 5'd5, 1'b0, 10'h3FF, 1'b1, 10'h002};
    tbl[4]  = '{4'd1, 5'd5, 5'd1, 5'd2, 1'b1, 10'h3FF, 1'b0, 10'h000};
    tbl[5]  = '{4'd3, 5'd9, 5'd1, 5'd2, 1'b1, 10'h3FF, 1'b0, 10'h000};
    tbl[6]  = '{4'd5, 5'd7, 5'd1, 5'd2, 1'b0, 10'h3DF, 1'b0, 10'h000};
    tbl[7]  = '{4'd5, 5'd7, 5'd1, 5'd2, 1'b0, 10'h3FF, 1'b1, 10'h020};
    tbl[8]  = '{4'd0, 5'd5, 5'd5, 5'd5, 1'b1, 10'h3FF, 1'b1, 10'h000};
    tbl[9]  = '{4'd12, 5'd5, 5'd5, 5'd5, 1'b1, 10'h3FF, 1'b1, 10'h000};
    tbl[10] = '{4'd7, 5'd9, 5'd1, 5'd2, 1'b1, 10'h3FF, 1'b1, 10'h080};
    tbl[11] = '{4'd9, 5'd9, 5'd1, 5'd2, 1'b1, 10'h3FF, 1'b1, 10'h200};

    // reset state
    step(); step();
    #2 rstn = 1'b1;
    step();
    chk("rst_busy", {22'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_err", {30'd0, err_illegal, err_spurious}, 32'd0);
    chk("rst_sel", {22'd0, fpu_in_valid}, 32'd0);
    chk("rst_perf", perf_issue | perf_stall | perf_raw, 32'd0);

    // basic fadd issue and writeback
    do_issue(4'd1, 5'd3, 5'd1, 5'd2, 1'b1, 10'h002);
    chk("fadd_busy", {22'd0, busy}, 32'h002);
    pulse(1, 32'h3F800000, 5'd3, 32'h3F800000, 1'b1);
    chk("fadd_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("fadd_wb_rd", {27'd0, wb_rd}, 32'd3);
    chk("fadd_wb_data", wb_data, 32'h3F800000);
    step();
    chk("fadd_retired", {21'd0, wb_valid, busy}, 32'd0);

    // table of issue-gating vectors against fmul rd=5 in flight
    do_issue(4'd3, 5'd5, 5'd0, 5'd0, 1'b0, 10'h008);
    for (int i = 0; i < 12; i++) begin
      iss_op = tbl[i].op; iss_rd = tbl[i].rd; iss_rs1 = tbl[i].rs1; iss_rs2 = tbl[i].rs2;
      iss_use_rs2 = tbl[i].use2; unit_ready = tbl[i].ur; iss_valid = 1'b1;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, iss_ready}, {31'd0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_sel", i), {22'd0, fpu_in_valid}, {22'd0, tbl[i].exp_fiv});
      $display("vec %0d op=%0d ready=%b sel=%h", i, tbl[i].op, iss_ready, fpu_in_valid);
      iss_valid = 1'b0;
      unit_ready = '1;
      step();
    end
    chk("tbl_no_err", {31'd0, err_illegal}, 32'd0);

    // RAW hazard: fadd rs1=5 waits for the fmul writeback handshake
    iss_op = 4'd1; iss_rd = 5'd6; iss_rs1 = 5'd5; iss_rs2 = 5'd1; iss_use_rs2 = 1'b1;
    iss_valid = 1'b1;
    #1;
    chk("raw_stall0", {31'd0, iss_ready}, 32'd0);
    step();
    chk("raw_stall1", {31'd0, iss_ready}, 32'd0);
    pulse(3, 32'h40000000, 5'd5, 32'h40000000, 1'b1);
    chk("raw_stall_cap", {30'd0, iss_ready, wb_valid}, 32'd1);
    step();
    chk("raw_go_ready", {31'd0, iss_ready}, 32'd1);
    chk("raw_go_sel", {22'd0, fpu_in_valid}, 32'h002);
    step();
    iss_valid = 1'b0;
    pulse(1, 32'h40400000, 5'd6, 32'h40400000, 1'b1);
    wait_drain();

    // structural hazard on fdiv
    do_issue(4'd4, 5'd10, 5'd11, 5'd12, 1'b1, 10'h010);
    iss_op = 4'd4; iss_rd = 5'd13; iss_rs1 = 5'd14; iss_rs2 = 5'd15; iss_use_rs2 = 1'b1;
    iss_valid = 1'b1;
    #1;
    chk("fdiv_stall", {31'd0, iss_ready}, 32'd0);
    chk("fdiv_busy", {22'd0, busy}, 32'h010);
    pulse(4, 32'h41000000, 5'd10, 32'h41000000, 1'b1);
    chk("fdiv_stall_wb", {31'd0, iss_ready}, 32'd0);
    step();
    chk("fdiv_go_ready", {31'd0, iss_ready}, 32'd1);
    chk("fdiv_go_sel", {22'd0, fpu_in_valid}, 32'h010);
    step();
    iss_valid = 1'b0;
    pulse(4, 32'h41100000, 5'd13, 32'h41100000, 1'b1);
    wait_drain();

    // fitof retire wraps the round-robin pointer back to unit 1
    do_issue(4'd9, 5'd17, 5'd16, 5'd18, 1'b0, 10'h200);
    pulse(9, 32'h4F000000, 5'd17, 32'h4F000000, 1'b1);
    wait_drain();

    // simultaneous completions on units 1, 3, 5 with writeback back-pressure
    do_issue(4'd1, 5'd1, 5'd21, 5'd22, 1'b1, 10'h002);
    do_issue(4'd3, 5'd2, 5'd21, 5'd22, 1'b1, 10'h008);
    do_issue(4'd5, 5'd4, 5'd21, 5'd22, 1'b0, 10'h020);
    wb_ready = 1'b0;
    unit_out[1] = 32'h11111111; unit_out[3] = 32'h33333333; unit_out[5] = 32'h55555555;
    unit_out_valid = 10'h02A;
    sb_q.push_back('{5'd1, 32'h11111111});
    sb_q.push_back('{5'd2, 32'h33333333});
    sb_q.push_back('{5'd4, 32'h55555555});
    step();
    unit_out_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("hold%0d_valid", c), {31'd0, wb_valid}, 32'd1);
      chk($sformatf("hold%0d_rd", c), {27'd0, wb_rd}, 32'd1);
      chk($sformatf("hold%0d_data", c), wb_data, 32'h11111111);
      if (c < 2) step();
    end
    wb_ready = 1'b1;
    wait_drain();
    chk("multi_busy", {22'd0, busy}, 32'd0);

    // fcmp result masking, spurious pulse, illegal op
    do_issue(4'd7, 5'd20, 5'd1, 5'd2, 1'b1, 10'h080);
    pulse(7, 32'hFFFFFF01, 5'd20, 32'h00000001, 1'b1);
    wait_drain();
    chk("spur_before", {31'd0, err_spurious}, 32'd0);
    pulse(6, 32'h12345678, 5'd0, 32'd0, 1'b0);
    chk("spur_after", {31'd0, err_spurious}, 32'd1);
    chk("spur_no_wb", {31'd0, wb_valid}, 32'd0);
    chk("ill_before", {31'd0, err_illegal}, 32'd0);
    do_issue(4'd15, 5'd3, 5'd3, 5'd3, 1'b1, 10'h000);
    chk("ill_after", {31'd0, err_illegal}, 32'd1);
    chk("ill_no_busy", {22'd0, busy}, 32'd0);

    // async reset with fdiv busy and a capture pending
    do_issue(4'd4, 5'd8, 5'd1, 5'd2, 1'b0, 10'h010);
    wb_ready = 1'b0;
    pulse(4, 32'h41200000, 5'd0, 32'd0, 1'b0);
    chk("prerst_wb_valid", {31'd0, wb_valid}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_busy", {22'd0, busy}, 32'd0);
    chk("arst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("arst_err", {30'd0, err_illegal, err_spurious}, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    wb_ready = 1'b1;
    step();
    do_issue(4'd4, 5'd8, 5'd1, 5'd2, 1'b0, 10'h010);
`ifdef FPU_SCHED_PERF_EN
    chk("perf_issue", perf_issue, 32'd1);
`else
    chk("perf_issue", perf_issue, 32'd0);
`endif
    pulse(4, 32'h41300000, 5'd8, 32'h41300000, 1'b1);
    wait_drain();
    chk("end_busy", {22'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_sched.md
Name: fpu_sched

Overview:
- Issue/completion scheduler for the FPU unit array (fadd, fsub, fmul, fdiv, fsqrt, fabs, fcmp, fftoi, fitof).
- Sits between the decode/issue stage and the FPU. Accepts one op per cycle and gates issue on per-unit busy state and a 32-entry FPR scoreboard.
- Drives the one-hot unit-select vector into the FPU.
- Captures variable-latency unit results and serialises them onto a single FPR writeback port with round-robin arbitration.

Parameters:
- NUNIT, 9, number of FPU units; ops encoded 1..NUNIT, code 0 = none.
- NREG, 32, FPR count; scoreboard depth.
- RR_INIT, 1, unit index given first writeback priority after reset.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- iss_valid  in  1  issue request
- iss_ready  out  1  issue accepted when high with iss_valid
- iss_op  in  4  op code 1..9 (1 fadd, 2 fsub, 3 fmul, 4 fdiv, 5 fsqrt, 6 fabs, 7 fcmp, 8 fftoi, 9 fitof)
- iss_rd  in  5  destination FPR
- iss_rs1  in  5  source 1 FPR
- iss_rs2  in  5  source 2 FPR
- iss_use_rs2  in  1  rs2 participates in hazard check
- fpu_in_valid  out  10  one-hot unit select; bit 0 unused, always 0
- unit_ready  in  10  per-unit input ready; bit 0 ignored
- unit_out_valid  in  10  per-unit result pulse; bit 0 ignored
- unit_out  in  10x32  per-unit result; index 0 ignored
- wb_valid  out  1  writeback valid
- wb_ready  in  1  writeback accepted
- wb_rd  out  5  writeback FPR
- wb_data  out  32  writeback data
- busy  out  10  registered per-unit busy mask
- err_illegal  out  1  sticky: illegal op accepted
- err_spurious  out  1  sticky: result pulse from an idle unit

Behaviour:
- Reset (async assert, sync release): busy, capture valids, scoreboard and error flags cleared; rr pointer = RR_INIT; all outputs 0. Any in-flight ops are dropped; units are reset by their own logic.
- Legal op k in 1..9:
  - iss_ready = !busy[k] && unit_ready[k] && !pend[rs1] && !(iss_use_rs2 && pend[rs2]) && !pend[rd].
  - All terms use registered state plus the live unit_ready.
- Illegal op (0, 10..15): iss_ready = 1. On accept, nothing is dispatched and err_illegal is set.
- Dispatch: fpu_in_valid[k] = iss_valid && iss_ready && legal, combinational in the same cycle.
- At the dispatch edge: busy[k] <= 1, tag[k] <= rd, pend[rd] <= 1.
- Capture: unit_out_valid[k] && busy[k] && !cap_v[k] → cap_v[k] <= 1, cap_d[k] <= unit_out[k].
  - For k = 7 (fcmp), bits [31:8] of the captured value are forced to 0.
  - unit_out_valid[k] with busy[k] = 0 → ignored; err_spurious set.
- Latency: unit_out_valid to wb_valid is 1 cycle minimum. Issue to dispatch is 0 cycles.
- Writeback arbitration:
  - wb_valid = |cap_v.
  - Grant goes to the first cap_v index at or after rr, wrapping 9 → 1.
  - wb_rd = tag[g], wb_data = cap_d[g], both held stable while wb_ready = 0.
  - On wb_valid && wb_ready: clear cap_v[g], busy[g] and pend[tag[g]]; rr <= g+1, wrapping 9 → 1.
- Simultaneous events:
  - Writeback retiring unit k and a new issue to k in the same cycle: the issue is stalled because busy is registered. The unit is available the next cycle.
  - Writeback clearing pend[r] and an issue hitting r in the same cycle: the issue is stalled and proceeds the next cycle.
  - Several units pulsing in the same cycle: all are captured; writeback drains them one per cycle in rr order.
- Grant must not change while wb_valid && !wb_ready.

Optional Feature:
- Macro FPU_SCHED_PERF_EN.
- Defined: adds three 32-bit saturating counters, cleared at reset, exposed as outputs:
  - perf_issue: legal dispatches.
  - perf_stall: cycles with iss_valid && !iss_ready.
  - perf_raw: stall cycles where the scoreboard was the blocking term.
- Undefined: the three ports exist but are tied to 0; no counter flops.

Test Plan:
- Issue fadd rd=3, rs1=1, rs2=2 with unit_ready[1] = 1 → fpu_in_valid = 10'b0000000010 the same cycle. Pulse unit_out_valid[1] with 0x3F800000 → next cycle wb_valid, wb_rd = 3, wb_data = 0x3F800000.
- RAW hazard: fmul rd=5 in flight, then issue fadd rs1=5 → iss_ready = 0 until the fmul writeback handshake; the fadd dispatches exactly 1 cycle after it.
- fdiv in flight (busy[4] = 1), issue a second fdiv with independent registers → stalled. Retire the first → the second dispatches the following cycle.
- fadd, fmul and fsqrt all pulse out_valid in the same cycle with rr = 1 and wb_ready held at 0 for 2 cycles → wb_rd and wb_data stay on the fadd result. Then writebacks drain in order units 1, 3, 5; busy returns to 0.
- fcmp returns 0xFFFFFF01 → wb_data = 0x00000001. Pulse unit_out_valid[6] while fabs is idle → err_spurious = 1, no writeback.
- Assert rstn = 0 while fdiv is busy and a capture is pending → busy = 0, wb_valid = 0 and all pend bits cleared asynchronously. A subsequent fdiv to the same rd issues immediately.
